project_select_ctrl: RTL



---
 rtl/project_select_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/project_select_ctrl.sv
`default_nettype none
// ============================================================================
// project_select_ctrl : Wishbone-programmed one-hot project enable with a
//                       forced all-inactive gap on every change.  Rev 1.0
// ============================================================================
module project_select_ctrl #(
  parameter int          NUM_PROJECTS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    busy_o,
  output logic                    switch_irq_o
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  localparam logic [4:0] NP = 5'(NUM_PROJECTS);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              gap_q, gap_d;
  logic [3:0]              req_idx_q, req_idx_d;
  logic                    req_en_q, req_en_d;
  logic [3:0]              cur_idx_q, cur_idx_d;
  logic                    cur_en_q, cur_en_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    irq_q, irq_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;

  logic       in_win, accept, wr, rd;
  logic [1:0] off;
  logic       tgt_en, pending, busy;
  logic       unused_ok;

  assign in_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept  = wbs_stb_i & wbs_cyc_i & ~ack_q & in_win;
  assign wr      = accept & wbs_we_i;
  assign rd      = accept & ~wbs_we_i;
  assign off     = wbs_adr_i[3:2];
  assign tgt_en  = req_en_q && ({1'b0, req_idx_q} < NP);
  // When the current config is disabled its index is irrelevant.
  assign pending = (tgt_en != cur_en_q) || (tgt_en && (req_idx_q != cur_idx_q));
  assign busy    = (state_q != ST_STABLE);

  assign unused_ok = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:9], wbs_adr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    req_idx_d = req_idx_q;
    req_en_d  = req_en_q;
    cur_idx_d = cur_idx_q;
    cur_en_d  = cur_en_q;
    active_d  = active_q;
    irq_d     = 1'b0;
    ack_d     = accept;
    dat_d     = 32'd0;

    if (rd) begin
      case (off)
        2'd0:    dat_d = {23'd0, req_en_q, 4'd0, req_idx_q};
        2'd1:    dat_d = {24'd0, gap_q};
        2'd2:    dat_d = {21'd0, pending, busy, cur_en_q, 4'd0, cur_idx_q};
        default: dat_d = 32'd0;
      endcase
    end

    if (wr && off == 2'd0) begin
      if (wbs_sel_i[0]) req_idx_d = wbs_dat_i[3:0];
      if (wbs_sel_i[1]) req_en_d  = wbs_dat_i[8];
    end
    if (wr && off == 2'd1 && wbs_sel_i[0]) gap_d = wbs_dat_i[7:0];

    case (state_q)
      ST_STABLE: begin
        if (pending) begin
          state_d  = ST_DRAIN;
          cnt_d    = gap_q;
          active_d = '0;
        end
      end
      ST_DRAIN: begin
        active_d = '0;
        if (cnt_q == 8'd0) state_d = ST_APPLY;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_APPLY: begin
        // Whatever target is in force now wins, even if it equals the old one.
        cur_en_d  = tgt_en;
        cur_idx_d = tgt_en ? req_idx_q : 4'd0;
        active_d  = tgt_en ? (NUM_PROJECTS'(1) << req_idx_q) : '0;
        irq_d     = 1'b1;
        state_d   = ST_STABLE;
      end
      default: begin
        active_d = '0;
        state_d  = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_STABLE;
      cnt_q     <= 8'd0;
      gap_q     <= 8'd4;
      req_idx_q <= 4'd0;
      req_en_q  <= 1'b0;
      cur_idx_q <= 4'd0;
      cur_en_q  <= 1'b0;
      active_q  <= '0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      req_idx_q <= req_idx_d;
      req_en_q  <= req_en_d;
      cur_idx_q <= cur_idx_d;
      cur_en_q  <= cur_en_d;
      active_q  <= active_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign active_o     = active_q;
  assign busy_o       = busy;
  assign switch_irq_o = irq_q;

  a_onehot0 : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
                               $onehot0(active_q));

endmodule
`default_nettype wire
